instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch.sv | 101 ++++++++++
 tb/tb_instr_fetch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions: fetch-stage state encoding and reset vector.
// The decode stage uses this package too.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Word-address increment; wraps modulo 2^32 by construction.
    function automatic logic [31:0] word_inc(input logic [31:0] addr);
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, a single Instruction
// Register toward decode, and redirect handling that can discard in-flight data.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_count
);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         load_ir;
    logic         deliver;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        addr_d   = addr_q;
        load_ir  = 1'b0;
        deliver  = 1'b0;
        imem_req = 1'b1;
        ir_valid = 1'b0;
        case (state)
            S_REQ: begin
                if (imem_ack && redirect_valid) begin
                    addr_d = redirect_pc;
                    pc_d   = redirect_pc;
                end else if (imem_ack) begin
                    load_ir = 1'b1;
                    pc_d    = word_inc(addr_q);
                    state_d = S_HOLD;
                end else if (redirect_valid) begin
                    // The memory still owes an ack for addr_q; keep the request up and drop it later.
                    pc_d    = redirect_pc;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                imem_req = 1'b0;
                ir_valid = 1'b1;
                deliver  = ir_ready;
                if (redirect_valid) begin
                    addr_d  = redirect_pc;
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (ir_ready) begin
                    addr_d  = pc;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (imem_ack) begin
                    addr_d  = redirect_valid ? redirect_pc : pc;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            addr_q      <= RESET_PC;
            ir          <= 32'h0;
            ir_pc       <= 32'h0;
            instr_count <= 32'h0;
        end else begin
            pc     <= pc_d;
            addr_q <= addr_d;
            if (load_ir) begin
                ir    <= imem_rdata;
                ir_pc <= addr_q;
            end
            if (deliver) instr_count <= instr_count + 32'd1;
        end
    end

    assign imem_addr = addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the fetch stage.
module tb_instr_fetch;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Memory responder state
    bit          in_flight;
    int          wait_cnt;
    int          mem_lat;
    bit          spurious_en;

    // Model: what the fetch stage is holding / owes
    bit          m_full;
    bit          m_stale;
    logic [31:0] m_pc, m_addr, m_ir, m_irpc, m_cnt;

    instr_fetch #(.RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 4) + 32'h20;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        m_stale = 1'b0;
        m_pc    = TB_RESET_PC;
        m_addr  = TB_RESET_PC;
        m_ir    = 32'h0;
        m_irpc  = 32'h0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_update();
        if (m_full) begin
            if (ir_ready) m_cnt = m_cnt + 32'd1;
            if (redirect_valid) begin
                m_addr = redirect_pc; m_pc = redirect_pc; m_full = 1'b0;
            end else if (ir_ready) begin
                m_addr = m_pc; m_full = 1'b0;
            end
        end else if (m_stale) begin
            if (redirect_valid) m_pc = redirect_pc;
            if (imem_ack) begin
                m_addr = m_pc; m_stale = 1'b0;
            end
        end else begin
            if (imem_ack && redirect_valid) begin
                m_addr = redirect_pc; m_pc = redirect_pc;
            end else if (imem_ack) begin
                m_ir = imem_rdata; m_irpc = m_addr; m_pc = m_addr + 32'd1; m_full = 1'b1;
            end else if (redirect_valid) begin
                m_pc = redirect_pc; m_stale = 1'b1;
            end
        end
    endtask

    task automatic compare_and_update();
        if (rst) model_reset();
        chk("imem_req",    {31'b0, imem_req}, {31'b0, ~m_full});
        chk("imem_addr",   imem_addr,         m_addr);
        chk("ir_valid",    {31'b0, ir_valid}, {31'b0, m_full});
        chk("ir",          ir,                m_ir);
        chk("ir_pc",       ir_pc,             m_irpc);
        chk("instr_count", instr_count,       m_cnt);
        if (!rst) model_update();
    endtask

    task automatic mem_drive();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (!in_flight) begin
                in_flight = 1'b1;
                wait_cnt  = mem_lat;
            end
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                in_flight  = 1'b0;
            end else begin
                wait_cnt--;
            end
        end else if (spurious_en && $urandom_range(0, 4) == 0) begin
            imem_ack = 1'b1;
        end
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk); #1;
        rst            = 1'b0;
        ir_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        mem_drive();
        @(negedge clk);
        compare_and_update();
    endtask

    task automatic reset_step(input logic junk_ack);
        @(posedge clk); #1;
        rst            = 1'b1;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = junk_ack;
        imem_rdata     = 32'hDEAD_BEEF;
        in_flight      = 1'b0;
        @(negedge clk);
        compare_and_update();
    endtask

    task automatic wait_valid(input logic rdy, input string tag);
        int n;
        n = 0;
        do begin
            step(rdy, 1'b0, 32'h0);
            n++;
        end while (!ir_valid && n < 40);
        if (!ir_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: ir_valid never rose (got 0 expected 1)", tag);
        end
    endtask

    initial begin
        rst = 1'b1; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        in_flight = 1'b0; wait_cnt = 0; mem_lat = 0; spurious_en = 1'b0;
        model_reset();

        reset_step(1'b0);
        reset_step(1'b0);
        chk("rst_imem_req",    {31'b0, imem_req}, 32'd1);
        chk("rst_imem_addr",   imem_addr, TB_RESET_PC);
        chk("rst_ir_valid",    {31'b0, ir_valid}, 32'd0);
        chk("rst_instr_count", instr_count, 32'd0);

        // First fetch, delivered immediately
        wait_valid(1'b1, "first_fetch");
        chk("first_ir",    ir,    32'h0000_0020);
        chk("first_ir_pc", ir_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("first_valid_one_cycle", {31'b0, ir_valid}, 32'd0);
        chk("next_req_addr",         imem_addr, 32'h1);
        chk("first_count",           instr_count, 32'd1);

        // Stall in HOLD
        wait_valid(1'b0, "stall_fetch");
        repeat (5) step(1'b0, 1'b0, 32'h0);
        chk("stall_ir",       ir,    32'h30);
        chk("stall_ir_pc",    ir_pc, 32'h1);
        chk("stall_imem_req", {31'b0, imem_req}, 32'd0);
        chk("stall_count",    instr_count, 32'd1);
        step(1'b1, 1'b0, 32'h0);
        mem_lat = 3;
        step(1'b0, 1'b0, 32'h0);
        chk("stall_release_count", instr_count, 32'd2);
        chk("slow_req_addr",       imem_addr, 32'h2);

        // Redirect while the slow request to addr 2 is pending
        step(1'b0, 1'b1, 32'h40);
        mem_lat = 0;
        wait_valid(1'b1, "redirect_pending");
        chk("redir_ir_pc", ir_pc, 32'h40);
        chk("redir_ir",    ir,    32'h420);

        // Redirect in the same cycle as the ack
        step(1'b0, 1'b1, 32'h80);
        step(1'b0, 1'b0, 32'h0);
        chk("ackredir_addr",  imem_addr, 32'h80);
        chk("ackredir_ir",    ir,        32'h420);
        chk("ackredir_valid", {31'b0, ir_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0);

        // Two redirects while dropping
        mem_lat = 4;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h10);
        step(1'b0, 1'b1, 32'h30);
        mem_lat = 0;
        wait_valid(1'b0, "double_redirect");
        chk("drop_ir_pc", ir_pc, 32'h30);
        chk("drop_ir",    ir,    32'h320);

        // Reset in the middle of a request to addr 7, with a stray ack during reset
        mem_lat = 5;
        step(1'b0, 1'b1, 32'h7);
        step(1'b0, 1'b0, 32'h0);
        chk("mid_req_addr", imem_addr, 32'h7);
        reset_step(1'b1);
        reset_step(1'b1);
        chk("midrst_imem_req", {31'b0, imem_req}, 32'd1);
        chk("midrst_addr",     imem_addr, TB_RESET_PC);
        chk("midrst_ir",       ir,    32'h0);
        chk("midrst_ir_pc",    ir_pc, 32'h0);
        chk("midrst_count",    instr_count, 32'd0);
        mem_lat = 0;
        wait_valid(1'b1, "post_reset_fetch");
        chk("postrst_ir",    ir,    32'h20);
        chk("postrst_ir_pc", ir_pc, TB_RESET_PC);

        // Randomized traffic, including wrap-around redirect targets and stray acks
        spurious_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            mem_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 299) == 0) begin
                reset_step(1'($urandom_range(0, 1)));
            end else begin
                logic [31:0] tgt;
                tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2)))
                                                  : 32'($urandom);
                step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 11) == 0), tgt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout expected finish)");
        $fatal(1, "watchdog");
    end

endmodule
